// File: rtl/exp_smoothing_filter_mc.sv
// rtl/exp_smoothing_filter_mc.sv - multi-channel time-multiplexed exponential smoothing filter
module exp_smoothing_filter_mc #(
    parameter int  CH       = 15,
    parameter int  IN_SIZE  = 17,
    parameter int  VAL_SIZE = 16,
    parameter int  BETA_W   = 5,
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_SIZE-1:0]  in,
    input  logic [CH_W-1:0]            in_ch,
    input  logic [BETA_W-1:0]          beta_shift,
    input  logic                       clr,
    output logic                       busy,
    output logic                       out_valid,
    output logic [CH_W-1:0]            out_ch,
    output logic signed [VAL_SIZE-1:0] out
);
    localparam int SUM = IN_SIZE + 1;
    localparam int W   = SUM + 1;
    localparam logic [CH_W:0]          CH_LIM  = (CH_W + 1)'(CH);
    localparam logic [CH_W-1:0]        LAST_CH = CH_W'(CH - 1);
    localparam logic signed [W-1:0]    VMAX    = {{(W - VAL_SIZE + 1){1'b0}}, {(VAL_SIZE - 1){1'b1}}};
    localparam logic signed [W-1:0]    VMIN    = ~VMAX;
    localparam logic signed [W-1:0]    ONE     = W'(1);

    logic signed [VAL_SIZE-1:0] state [CH];
    logic [CH-1:0]              seeded;

    logic                       s1_valid;
    logic signed [IN_SIZE-1:0]  s1_in;
    logic [CH_W-1:0]            s1_ch;
    logic [BETA_W-1:0]          s1_beta;

    logic [CH_W-1:0]            clr_idx;
    logic                       accept;

    logic signed [VAL_SIZE-1:0] curr;
    logic signed [VAL_SIZE-1:0] next_val;
    logic signed [W-1:0]        curr_w;
    logic signed [W-1:0]        in_w;
    logic signed [W-1:0]        diff;
    logic signed [W-1:0]        shifted;
    logic signed [W-1:0]        rounded;
    logic signed [W-1:0]        step;
    logic signed [W-1:0]        sum;

    function automatic logic signed [VAL_SIZE-1:0] sat(input logic signed [W-1:0] v);
        if (v > VMAX)
            return VMAX[VAL_SIZE-1:0];
        else if (v < VMIN)
            return VMIN[VAL_SIZE-1:0];
        else
            return v[VAL_SIZE-1:0];
    endfunction

    assign in_ready = !busy;
    assign accept   = in_valid && !busy && ({1'b0, in_ch} < CH_LIM);

    // State is written at the end of the S2 cycle, so a following same-channel
    // sample in S2 already reads the fresh value: sequential semantics hold.
    always_comb begin
        curr     = state[s1_ch];
        curr_w   = {{(W - VAL_SIZE){curr[VAL_SIZE-1]}}, curr};
        in_w     = {{(W - IN_SIZE){s1_in[IN_SIZE-1]}}, s1_in};
        diff     = in_w - curr_w;
        shifted  = '0;
        rounded  = '0;
        step     = diff;
        if (s1_beta == '0) begin
            step = diff;
        end else if (int'(s1_beta) > SUM - 1) begin
            step = '0;
        end else begin
            shifted = diff >>> (s1_beta - BETA_W'(1));
            rounded = shifted + ONE;
            step    = rounded >>> 1;
        end
        sum = curr_w + step;
        if (!seeded[s1_ch])
            sum = in_w;
        next_val = sat(sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_in     <= '0;
            s1_ch     <= '0;
            s1_beta   <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out       <= '0;
            busy      <= 1'b0;
            clr_idx   <= '0;
            seeded    <= '0;
            for (int i = 0; i < CH; i++)
                state[i] <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_in   <= in;
                s1_ch   <= in_ch;
                s1_beta <= beta_shift;
            end

            out_valid <= s1_valid;
            if (s1_valid) begin
                out            <= next_val;
                out_ch         <= s1_ch;
                state[s1_ch]   <= next_val;
                seeded[s1_ch]  <= 1'b1;
            end

            if (clr) begin
                busy    <= 1'b1;
                clr_idx <= '0;
            end else if (busy) begin
                clr_idx <= clr_idx + CH_W'(1);
                if (clr_idx == LAST_CH)
                    busy <= 1'b0;
            end

            // Sweep write comes last so it wins over a same-index pipeline write.
            if (busy) begin
                state[clr_idx]  <= '0;
                seeded[clr_idx] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exp_smoothing_filter_mc.sv
// tb/tb_exp_smoothing_filter_mc.sv - directed self-checking bench for exp_smoothing_filter_mc
module tb_exp_smoothing_filter_mc;
    localparam int CH       = 15;
    localparam int IN_SIZE  = 17;
    localparam int VAL_SIZE = 16;
    localparam int BETA_W   = 5;
    localparam int CH_W     = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [IN_SIZE-1:0]  in;
    logic [CH_W-1:0]            in_ch;
    logic [BETA_W-1:0]          beta_shift;
    logic                       clr;
    logic                       busy;
    logic                       out_valid;
    logic [CH_W-1:0]            out_ch;
    logic signed [VAL_SIZE-1:0] out;

    exp_smoothing_filter_mc #(
        .CH(CH), .IN_SIZE(IN_SIZE), .VAL_SIZE(VAL_SIZE), .BETA_W(BETA_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in(in), .in_ch(in_ch), .beta_shift(beta_shift), .clr(clr),
        .busy(busy), .out_valid(out_valid), .out_ch(out_ch), .out(out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int ch;
        int val;
    } exp_t;
    exp_t expq[$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                check("out", int'(out), e.val);
                check("out_ch", int'(out_ch), e.ch);
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int ch, input int val, input int b, input bit exp_out, input int exp_val);
        in_valid   = 1'b1;
        in_ch      = CH_W'(ch);
        in         = IN_SIZE'(val);
        beta_shift = BETA_W'(b);
        if (exp_out)
            expq.push_back('{cyc + 2, ch, exp_val});
        tick(1);
        in_valid = 1'b0;
    endtask

    int n_busy;
    int n_nr;
    int ov_seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in = '0; in_ch = '0; beta_shift = '0; clr = 1'b0;
        tick(3);
        check("reset_out", int'(out), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_ch", int'(out_ch), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        tick(1);

        // seed then smoothing step with rounding
        drive(0, 1000, 4, 1, 1000);
        drive(0, 2000, 4, 1, 1063);
        drive(1, 0, 4, 1, 0);
        drive(1, -24, 4, 1, -1);
        drive(1, -8, 4, 1, -1);
        // saturation
        drive(3, 65535, 4, 1, 32767);
        drive(3, 65535, 0, 1, 32767);
        drive(3, -65536, 0, 1, -32768);
        // oversized shift and b=1 half-up rounding
        drive(7, 300, 3, 1, 300);
        drive(7, -5000, 20, 1, 300);
        drive(7, 301, 1, 1, 301);
        drive(7, 300, 1, 1, 301);
        // back-to-back same channel
        drive(2, 0, 4, 1, 0);
        drive(2, 160, 4, 1, 10);
        drive(2, 160, 4, 1, 19);
        tick(4);

        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        drive(2, 0, 4, 1, 0);
        drive(5, 100, 4, 1, 100);
        drive(2, 160, 4, 1, 10);
        drive(5, 100, 4, 1, 100);
        drive(2, 160, 4, 1, 19);
        drive(15, 123, 0, 0, 0);
        tick(4);

        // clear sweep with samples still in flight and one offered during it
        drive(0, 100, 0, 1, 100);
        drive(6, 200, 0, 1, 200);
        clr = 1'b1; tick(1); clr = 1'b0;
        n_busy = 0; n_nr = 0;
        in_valid = 1'b1; in_ch = '0; in = IN_SIZE'(7); beta_shift = '0;
        while (busy && n_busy < 40) begin
            n_busy++;
            if (!in_ready) n_nr++;
            tick(1);
        end
        in_valid = 1'b0;
        check("busy_cycles", n_busy, 15);
        check("not_ready_cycles", n_nr, 15);
        drive(0, 500, 4, 1, 500);
        drive(6, 50, 4, 1, 50);
        tick(4);

        // restart mid-sweep
        clr = 1'b1; tick(1); clr = 1'b0;
        tick(4);
        check("busy_before_restart", int'(busy), 1);
        clr = 1'b1; tick(1); clr = 1'b0;
        n_busy = 0;
        while (busy && n_busy < 40) begin
            n_busy++;
            tick(1);
        end
        check("restart_busy_cycles", n_busy, 15);
        tick(2);

        // reset while a sample is in flight
        drive(4, 1000, 4, 0, 0);
        rst = 1'b1; tick(1); rst = 1'b0;
        ov_seen = 0;
        repeat (4) begin
            if (out_valid) ov_seen++;
            tick(1);
        end
        check("midflight_out_valid", ov_seen, 0);
        drive(4, 200, 4, 1, 200);
        tick(4);

        check("pending_expected", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exp_smoothing_filter_mc.md
Name: exp_smoothing_filter_mc

Overview:
- Multi-channel, time-multiplexed exponential smoothing filter: next = curr + beta*(in - curr), with beta = 2^-beta_shift.
- Holds CH independent channel states, with per-sample channel addressing and per-sample runtime beta.
- Rounds half-up, saturates instead of wrapping, and seeds each channel from its first sample.
- Sits after the rxx/correlation estimators in the RACE adaptive filter; replaces the fixed cyclic single-beta smoother.

Parameters:
- CH, 15: number of channels (2L+1 for L=7); CH_W = max(1, clog2(CH)) is a derived localparam.
- IN_SIZE, 17: signed input width; must be >= VAL_SIZE.
- VAL_SIZE, 16: signed state/output width.
- BETA_W, 5: width of the beta_shift port.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample strobe
- in_ready  out  1  high when a sample is accepted; equals !busy
- in  in  IN_SIZE  signed sample
- in_ch  in  CH_W  target channel
- beta_shift  in  BETA_W  smoothing shift, sampled with the sample
- clr  in  1  pulse that starts a sweep clearing all channel states and seed flags
- busy  out  1  clear sweep in progress
- out_valid  out  1  result strobe
- out_ch  out  CH_W  channel of the result
- out  out  VAL_SIZE  signed updated channel value

Behaviour:
- Reset: synchronous, active-high. Sets out=0, out_ch=0, out_valid=0, busy=0, all CH states=0, all seed flags=0. Both pipeline stages are flushed; an in-flight sample produces no output and no write.
- Accept: a sample is accepted when in_valid && in_ready. in_ch >= CH: sample dropped, no output, no write.
- Pipeline: two stages.
  - S1 registers in, in_ch, beta_shift.
  - S2 reads state[ch] and seed[ch], computes, writes state[ch], sets seed[ch]=1, and registers out/out_ch/out_valid.
  - Latency: out_valid is high exactly 2 cycles after acceptance.
  - Throughput: one sample per cycle.
- Hazard: back-to-back samples to the same channel must use the just-computed value via forwarding. Results equal strictly sequential evaluation, for any channel interleaving.
- Arithmetic:
  - diff = in - curr, SUM = IN_SIZE+1 bits signed; curr is sign-extended.
  - b=0: step = diff.
  - b>=1: step = ((diff >>> (b-1)) + 1) >>> 1, i.e. round half toward +inf.
  - next = sat_VAL(curr + step), where sat_VAL clamps to [-2^(VAL_SIZE-1), 2^(VAL_SIZE-1)-1].
  - b > SUM-1 gives step = 0.
- Seed: if seed[ch]=0, next = sat_VAL(in), regardless of beta.
- Clear:
  - A clr pulse when idle sets busy=1 and clears one channel per cycle, index 0..CH-1. busy drops after exactly CH cycles.
  - in_ready=0 throughout. Samples already in the pipeline complete and write before the sweep reaches them; the sweep overwrites them.
  - clr while busy restarts the sweep at index 0.
  - clr and rst together: rst wins.
- out holds its last value while out_valid=0.

Test Plan:
- rst; ch0: in=1000, b=4 → out=1000 (seed). Then in=2000, b=4 → out=1063, out_ch=0, 2 cycles after each accept.
- ch1 seeded 0; in=-24, b=4 → out=-1. Then in=-8, b=4 → diff=-7, step=0 → out=-1.
- Saturation: ch3 in=65535 → out=32767 (seed clamps). Then in=65535, b=0 → out=32767. Then in=-65536, b=0 → out=-32768.
- Forwarding: ch2 in=0, 160, 160 on consecutive cycles, b=4 → out=0, 10, 19. Repeat interleaved as ch2,ch5,ch2 with ch5 in=100 → ch2 results identical; ch5 out=100.
- Clear (CH=15): seed several channels; pulse clr → busy=1 and in_ready=0 for exactly 15 cycles. A sample offered meanwhile is dropped (no out_valid). Afterwards ch0 in=500 → out=500 (reseeded). Pulse clr again mid-sweep → busy extends to 15 cycles from the restart.
- Reset mid-flight: accept sample, assert rst next cycle → out_valid stays 0, state unchanged at 0. in_ch=15 when CH=15 → no output.
